// File: rtl/cache_ctrl_fsm_pkg.sv
// Shared types for the L1 request sequencer: line coherence states and controller states.
package cache_pkg;

  typedef enum logic [1:0] {
    LS_I  = 2'b00,
    LS_S  = 2'b01,
    LS_UC = 2'b10,
    LS_UD = 2'b11
  } line_state_t;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WB_ISSUE,
    WB_WAIT,
    RF_ISSUE,
    RF_WAIT,
    UP_ISSUE,
    UP_WAIT
  } ctrl_state_t;

  function automatic logic lookup_hit(input logic tag_hit, input line_state_t ls);
    return tag_hit && (ls != LS_I);
  endfunction

endpackage

// File: rtl/cache_ctrl_fsm_timeout.sv
// Bus-response watchdog: down-counter reloaded on clear, flags the TIMEOUT-th enabled cycle.
module ace_timeout_ctr #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LOAD = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
  localparam bit ENABLED = (TIMEOUT > 0);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = LOAD;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The first enabled cycle after clear sees LOAD, so zero marks the TIMEOUT-th cycle.
  assign expired = ENABLED && en && (cnt_q == '0);

endmodule

// File: rtl/cache_ctrl_fsm.sv
// L1 request sequencer: classifies CPU accesses and drives ACE requests and line array writes.
//
// state    | meaning
// IDLE     | ready for a CPU access
// LOOKUP   | tag/state result valid, classify hit/miss/upgrade
// WB_ISSUE | send WriteClean for dirty victim
// WB_WAIT  | wait for writeback completion
// RF_ISSUE | send ReadShared for refill
// RF_WAIT  | wait for refill data
// UP_ISSUE | send MakeUnique for store to shared line
// UP_WAIT  | wait for upgrade completion
module cache_ctrl_fsm
  import cache_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cpu_req_valid,
  input  logic             cpu_req_we,
  output logic             cpu_req_ready,
  output logic             cpu_resp_valid,
  output logic             cpu_err,
  output logic             tag_rd_en,
  input  logic             tag_hit,
  input  logic [1:0]       line_state,
  output logic             wb_rd_en,
  output logic             data_we,
  output logic             refill_we,
  output logic             state_we,
  output logic [1:0]       state_nxt,
  input  logic             snoop_active,
  output logic             read_req,
  output logic             write_req,
  output logic             invalid_req,
  input  logic             ace_ready,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  ctrl_state_t      state_q, state_d;
  logic             we_q, we_d;
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

  line_state_t ls;
  logic        hit;
  logic        in_wait;
  logic        tmo_clear;
  logic        tmo_expired;

  assign ls        = line_state_t'(line_state);
  assign hit       = lookup_hit(tag_hit, ls);
  assign in_wait   = (state_q == WB_WAIT) || (state_q == RF_WAIT) || (state_q == UP_WAIT);
  assign tmo_clear = read_req || write_req || invalid_req;

  ace_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_tmo (
    .clk    (clk),
    .rst    (rst),
    .clear  (tmo_clear),
    .en     (in_wait),
    .expired(tmo_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    unique case (state_q)
      IDLE: begin
        if (cpu_req_valid) begin
          we_d    = cpu_req_we;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit) begin
          state_d = (we_q && (ls == LS_S)) ? UP_ISSUE : IDLE;
        end else begin
          state_d = (ls == LS_UD) ? WB_ISSUE : RF_ISSUE;
        end
      end
      WB_ISSUE: if (!snoop_active) state_d = WB_WAIT;
      RF_ISSUE: if (!snoop_active) state_d = RF_WAIT;
      UP_ISSUE: if (!snoop_active) state_d = UP_WAIT;
      WB_WAIT: begin
        if (ace_ready)        state_d = RF_ISSUE;
        else if (tmo_expired) state_d = IDLE;
      end
      RF_WAIT: begin
        if (ace_ready)        state_d = we_q ? UP_ISSUE : IDLE;
        else if (tmo_expired) state_d = IDLE;
      end
      UP_WAIT: begin
        if (ace_ready || tmo_expired) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cpu_req_ready  = 1'b0;
    cpu_resp_valid = 1'b0;
    cpu_err        = 1'b0;
    tag_rd_en      = 1'b0;
    wb_rd_en       = 1'b0;
    data_we        = 1'b0;
    refill_we      = 1'b0;
    state_we       = 1'b0;
    state_nxt      = LS_I;
    read_req       = 1'b0;
    write_req      = 1'b0;
    invalid_req    = 1'b0;
    unique case (state_q)
      IDLE: begin
        cpu_req_ready = 1'b1;
        tag_rd_en     = cpu_req_valid;
      end
      LOOKUP: begin
        if (hit) begin
          if (!we_q) begin
            cpu_resp_valid = 1'b1;
          end else if (ls != LS_S) begin
            data_we        = 1'b1;
            state_we       = 1'b1;
            state_nxt      = LS_UD;
            cpu_resp_valid = 1'b1;
          end
        end else begin
          wb_rd_en = (ls == LS_UD);
        end
      end
      WB_ISSUE: write_req   = !snoop_active;
      RF_ISSUE: read_req    = !snoop_active;
      UP_ISSUE: invalid_req = !snoop_active;
      // A completion in the expiry cycle takes priority over the error path.
      WB_WAIT: begin
        if (ace_ready) begin
          state_we  = 1'b1;
          state_nxt = LS_I;
        end else if (tmo_expired) begin
          cpu_resp_valid = 1'b1;
          cpu_err        = 1'b1;
        end
      end
      RF_WAIT: begin
        if (ace_ready) begin
          refill_we      = 1'b1;
          state_we       = 1'b1;
          state_nxt      = LS_S;
          cpu_resp_valid = !we_q;
        end else if (tmo_expired) begin
          cpu_resp_valid = 1'b1;
          cpu_err        = 1'b1;
        end
      end
      UP_WAIT: begin
        if (ace_ready) begin
          data_we        = 1'b1;
          state_we       = 1'b1;
          state_nxt      = LS_UD;
          cpu_resp_valid = 1'b1;
        end else if (tmo_expired) begin
          cpu_resp_valid = 1'b1;
          cpu_err        = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (state_q == LOOKUP) begin
      if (hit && (hit_cnt_q != '1))   hit_cnt_d  = hit_cnt_q + CNT_W'(1);
      if (!hit && (miss_cnt_q != '1)) miss_cnt_d = miss_cnt_q + CNT_W'(1);
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;

endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// Scoreboard bench for cache_ctrl_fsm: expected per-access signatures queued at issue, checked on response.
module tb_cache_ctrl_fsm;
  import cache_pkg::*;

  localparam int CNT_W = 2;

  logic clk = 1'b0;
  logic rst;
  logic cpu_req_valid, cpu_req_we, cpu_req_ready, cpu_resp_valid, cpu_err;
  logic tag_rd_en, tag_hit, wb_rd_en, data_we, refill_we, state_we;
  logic [1:0] line_state, state_nxt;
  logic snoop_active, read_req, write_req, invalid_req, ace_ready;
  logic [CNT_W-1:0] hit_cnt, miss_cnt;

  always #5 clk = ~clk;

  cache_ctrl_fsm #(.CNT_W(CNT_W), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .cpu_req_valid(cpu_req_valid), .cpu_req_we(cpu_req_we), .cpu_req_ready(cpu_req_ready),
    .cpu_resp_valid(cpu_resp_valid), .cpu_err(cpu_err), .tag_rd_en(tag_rd_en),
    .tag_hit(tag_hit), .line_state(line_state), .wb_rd_en(wb_rd_en), .data_we(data_we),
    .refill_we(refill_we), .state_we(state_we), .state_nxt(state_nxt),
    .snoop_active(snoop_active), .read_req(read_req), .write_req(write_req),
    .invalid_req(invalid_req), .ace_ready(ace_ready), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  typedef struct {
    int err, lat, freq, rd, wr, inv, dwe, rwe, swe, wb;
    int seq;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  function automatic exp_t mk(int err, int lat, int freq, int rd, int wr, int inv,
                              int dwe, int rwe, int swe, int wb, int seq);
    exp_t e;
    e.err = err; e.lat = lat; e.freq = freq; e.rd = rd; e.wr = wr; e.inv = inv;
    e.dwe = dwe; e.rwe = rwe; e.swe = swe; e.wb = wb; e.seq = seq;
    return e;
  endfunction

  // Monitor: accumulates activity since the last accept, compares on each response.
  int cyc, a_first, a_rd, a_wr, a_inv, a_dwe, a_rwe, a_swe, a_wb, a_tag, a_multi, nreq;
  logic [7:0] a_seq;

  task automatic clr_acc();
    cyc = 0; a_first = 0; a_rd = 0; a_wr = 0; a_inv = 0; a_dwe = 0; a_rwe = 0;
    a_swe = 0; a_wb = 0; a_tag = 0; a_multi = 0; a_seq = '0;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      clr_acc();
    end else begin
      if (cpu_req_valid && cpu_req_ready) clr_acc();
      else cyc++;
      nreq = int'(read_req) + int'(write_req) + int'(invalid_req);
      if (nreq > 1) a_multi++;
      if (nreq > 0 && a_first == 0) a_first = cyc;
      a_rd  += int'(read_req);
      a_wr  += int'(write_req);
      a_inv += int'(invalid_req);
      a_dwe += int'(data_we);
      a_rwe += int'(refill_we);
      a_swe += int'(state_we);
      a_wb  += int'(wb_rd_en);
      a_tag += int'(tag_rd_en);
      if (state_we) a_seq = {a_seq[5:0], state_nxt};
      if (cpu_resp_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp: got response with empty queue, expected none");
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("err", int'(cpu_err), e.err);
          chk("latency", cyc, e.lat);
          chk("first_req_cycle", a_first, e.freq);
          chk("read_req_cnt", a_rd, e.rd);
          chk("write_req_cnt", a_wr, e.wr);
          chk("invalid_req_cnt", a_inv, e.inv);
          chk("data_we_cnt", a_dwe, e.dwe);
          chk("refill_we_cnt", a_rwe, e.rwe);
          chk("state_we_cnt", a_swe, e.swe);
          chk("state_seq", int'(a_seq), e.seq);
          chk("wb_rd_en_cnt", a_wb, e.wb);
          chk("tag_rd_en_cnt", a_tag, 1);
          chk("multi_req_cycles", a_multi, 0);
        end
      end
    end
  end

  task automatic issue(input logic we, input logic th, input logic [1:0] ls);
    @(posedge clk); #1;
    cpu_req_valid = 1'b1; cpu_req_we = we; tag_hit = th; line_state = ls;
    @(posedge clk); #1;
    cpu_req_valid = 1'b0;
  endtask

  task automatic ace_respond(input int d);
    int n;
    n = 0;
    @(negedge clk);
    while (!(read_req || write_req || invalid_req) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("ace_req_seen", 0, 1);
    repeat (d) @(posedge clk);
    #1 ace_ready = 1'b1;
    @(posedge clk);
    #1 ace_ready = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cpu_req_ready && n < 100);
    if (n >= 100) chk("return_to_idle", 0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cpu_req_valid = 1'b0; cpu_req_we = 1'b0; tag_hit = 1'b0;
    line_state = LS_I; snoop_active = 1'b0; ace_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", int'(cpu_req_ready), 1);
    chk("rst_resp", int'(cpu_resp_valid), 0);
    chk("rst_outputs", int'({cpu_err, tag_rd_en, wb_rd_en, data_we, refill_we, state_we,
                              read_req, write_req, invalid_req}), 0);
    chk("rst_hit_cnt", int'(hit_cnt), 0);
    chk("rst_miss_cnt", int'(miss_cnt), 0);

    // Load hit on S
    exp_q.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    issue(1'b0, 1'b1, LS_S);
    wait_idle();
    chk("hit_cnt_t1", int'(hit_cnt), 1);
    chk("miss_cnt_t1", int'(miss_cnt), 0);

    // Store hit on UC
    exp_q.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0, 1, 0, 3));
    issue(1'b1, 1'b1, LS_UC);
    wait_idle();

    // Store hit on S: upgrade, completion in 5th wait cycle
    exp_q.push_back(mk(0, 7, 2, 0, 0, 1, 1, 0, 1, 0, 3));
    issue(1'b1, 1'b1, LS_S);
    ace_respond(5);
    wait_idle();
    chk("hit_cnt_t3", int'(hit_cnt), 3);

    // Load hit on UD: hit counter saturated
    exp_q.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    issue(1'b0, 1'b1, LS_UD);
    wait_idle();
    chk("hit_cnt_sat", int'(hit_cnt), 3);

    // Load miss, dirty victim: writeback then refill
    exp_q.push_back(mk(0, 8, 2, 1, 1, 0, 0, 1, 2, 1, 1));
    issue(1'b0, 1'b0, LS_UD);
    ace_respond(3);
    ace_respond(2);
    wait_idle();
    chk("miss_cnt_t4", int'(miss_cnt), 1);

    // Store miss, clean victim: refill then upgrade
    exp_q.push_back(mk(0, 6, 2, 1, 0, 1, 1, 1, 2, 0, 7));
    issue(1'b1, 1'b0, LS_S);
    ace_respond(2);
    ace_respond(1);
    wait_idle();

    // Snoop holds RF_ISSUE for 10 cycles
    snoop_active = 1'b1;
    exp_q.push_back(mk(0, 14, 12, 1, 0, 0, 0, 1, 1, 0, 1));
    issue(1'b0, 1'b0, LS_UC);
    repeat (11) @(posedge clk);
    #1 snoop_active = 1'b0;
    ace_respond(2);
    wait_idle();
    chk("miss_cnt_t6", int'(miss_cnt), 3);

    // Tag match on invalid line is a miss
    exp_q.push_back(mk(0, 3, 2, 1, 0, 0, 0, 1, 1, 0, 1));
    issue(1'b0, 1'b1, LS_I);
    ace_respond(1);
    wait_idle();
    chk("miss_cnt_sat", int'(miss_cnt), 3);

    // Timeout: no ace_ready, error on 8th wait cycle
    exp_q.push_back(mk(1, 10, 2, 1, 0, 0, 0, 0, 0, 0, 0));
    issue(1'b0, 1'b0, LS_I);
    wait_idle();

    // ace_ready on the 8th wait cycle wins over timeout
    exp_q.push_back(mk(0, 10, 2, 1, 0, 0, 0, 1, 1, 0, 1));
    issue(1'b0, 1'b0, LS_I);
    ace_respond(8);
    wait_idle();

    // Reset while in RF_WAIT: no response, counters cleared
    issue(1'b0, 1'b0, LS_S);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_ready", int'(cpu_req_ready), 1);
    chk("abort_hit_cnt", int'(hit_cnt), 0);
    chk("abort_miss_cnt", int'(miss_cnt), 0);
    repeat (10) @(negedge clk);

    // Normal operation after abort
    exp_q.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    issue(1'b0, 1'b1, LS_UC);
    wait_idle();
    chk("post_abort_hit_cnt", int'(hit_cnt), 1);

    repeat (3) @(negedge clk);
    chk("pending_expected", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
